// File: rtl/bf16_adder_arbiter_if.sv
// Bundle of requester, adder and response signals around bf16_adder_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding clients, adder and response consumer.
interface bf16_adder_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [16*NUM_REQ-1:0] req_a;
   logic [16*NUM_REQ-1:0] req_b;
   logic [15:0]           add_a;
   logic [15:0]           add_b;
   logic                  add_start;
   logic                  add_done;
   logic [15:0]           add_sum;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [15:0]           rsp_sum;
   logic                  rsp_timeout;
   logic [15:0]           op_count;
   logic [1:0]            dbg_state;

   modport slave (
      input  req_valid, req_a, req_b, add_done, add_sum, rsp_ready,
      output req_ready, add_a, add_b, add_start, rsp_valid, rsp_id, rsp_sum,
             rsp_timeout, op_count, dbg_state
   );

   modport master (
      output req_valid, req_a, req_b, add_done, add_sum, rsp_ready,
      input  req_ready, add_a, add_b, add_start, rsp_valid, rsp_id, rsp_sum,
             rsp_timeout, op_count, dbg_state
   );
endinterface

// File: rtl/bf16_adder_arbiter.sv
// bf16_adder_arbiter: shares one multi-cycle bfloat16 adder among NUM_REQ
// requesters, granting round-robin and answering each operation with a sum
// tagged by requester index, or a quiet NaN if the adder's watchdog expires.
//
// Handshakes: a request transfers in the cycle req_valid[i] & req_ready[i]
// (req_ready is a one-cycle grant pulse, never asserted otherwise); a response
// transfers in the cycle rsp_valid & rsp_ready, and every rsp_* output holds
// steady until then; add_start is a one-cycle command and add_done a one-cycle
// result strobe, neither of which can be back-pressured.
module bf16_adder_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 64,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input logic                 clock,
   input logic                 n_reset,
   bf16_adder_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT    = 2'd2,
      S_RESPOND = 2'd3
   } state_t;

   localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);
   localparam logic [15:0] QNAN         = 16'h7FC1;

   state_t             state_q, state_d;
   logic [IDW-1:0]     ptr_q, ptr_d;
   logic [IDW-1:0]     gnt_q, gnt_d;
   logic [7:0]         wait_cnt_q, wait_cnt_d;
   logic [15:0]        add_a_q, add_a_d;
   logic [15:0]        add_b_q, add_b_d;
   logic               add_start_q, add_start_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]     rsp_id_q, rsp_id_d;
   logic [15:0]        rsp_sum_q, rsp_sum_d;
   logic               rsp_timeout_q, rsp_timeout_d;
   logic [15:0]        op_count_q, op_count_d;

   logic               sel_valid;
   logic [IDW-1:0]     sel_idx;
   logic [15:0]        sel_a;
   logic [15:0]        sel_b;
   logic               timed_out;
   logic [NUM_REQ-1:0] req_ready_c;

   assign timed_out = (wait_cnt_q == TIMEOUT_LAST);

   // Round-robin pick: first valid requester searching upward from ptr+1, wrapping.
   always_comb begin
      int cand;
      cand      = 0;
      sel_valid = 1'b0;
      sel_idx   = '0;
      sel_a     = '0;
      sel_b     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = (int'(ptr_q) + k) % NUM_REQ;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!sel_valid && (cand == i) && bus.req_valid[i]) begin
               sel_valid = 1'b1;
               sel_idx   = IDW'(i);
               sel_a     = bus.req_a[16*i +: 16];
               sel_b     = bus.req_b[16*i +: 16];
            end
         end
      end
   end

   // State register.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: done beats the watchdog when both happen in one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (sel_valid) state_d = S_ISSUE;
         S_ISSUE:   state_d = S_WAIT;
         S_WAIT:    if (bus.add_done || timed_out) state_d = S_RESPOND;
         S_RESPOND: if (bus.rsp_ready) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Output and datapath next values; req_ready is the only unregistered output.
   always_comb begin
      ptr_d         = ptr_q;
      gnt_d         = gnt_q;
      wait_cnt_d    = wait_cnt_q;
      add_a_d       = add_a_q;
      add_b_d       = add_b_q;
      add_start_d   = 1'b0;
      rsp_valid_d   = rsp_valid_q;
      rsp_id_d      = rsp_id_q;
      rsp_sum_d     = rsp_sum_q;
      rsp_timeout_d = rsp_timeout_q;
      op_count_d    = op_count_q;
      req_ready_c   = '0;
      case (state_q)
         S_IDLE: begin
            if (sel_valid) begin
               for (int i = 0; i < NUM_REQ; i++) begin
                  req_ready_c[i] = n_reset && (sel_idx == IDW'(i));
               end
               add_a_d     = sel_a;
               add_b_d     = sel_b;
               gnt_d       = sel_idx;
               add_start_d = 1'b1;
            end
         end
         S_ISSUE: begin
            wait_cnt_d = '0;
         end
         S_WAIT: begin
            if (bus.add_done) begin
               rsp_valid_d   = 1'b1;
               rsp_id_d      = gnt_q;
               rsp_sum_d     = bus.add_sum;
               rsp_timeout_d = 1'b0;
            end else if (timed_out) begin
               rsp_valid_d   = 1'b1;
               rsp_id_d      = gnt_q;
               rsp_sum_d     = QNAN;
               rsp_timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         S_RESPOND: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               ptr_d       = gnt_q;
               op_count_d  = op_count_q + 16'd1;
            end
         end
         default: begin
         end
      endcase
   end

   // Datapath and registered outputs; reset drops any operation in flight.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         ptr_q         <= IDW'(NUM_REQ - 1);
         gnt_q         <= '0;
         wait_cnt_q    <= '0;
         add_a_q       <= '0;
         add_b_q       <= '0;
         add_start_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_id_q      <= '0;
         rsp_sum_q     <= '0;
         rsp_timeout_q <= 1'b0;
         op_count_q    <= '0;
      end else begin
         ptr_q         <= ptr_d;
         gnt_q         <= gnt_d;
         wait_cnt_q    <= wait_cnt_d;
         add_a_q       <= add_a_d;
         add_b_q       <= add_b_d;
         add_start_q   <= add_start_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_id_q      <= rsp_id_d;
         rsp_sum_q     <= rsp_sum_d;
         rsp_timeout_q <= rsp_timeout_d;
         op_count_q    <= op_count_d;
      end
   end

   assign bus.req_ready   = req_ready_c;
   assign bus.add_a       = add_a_q;
   assign bus.add_b       = add_b_q;
   assign bus.add_start   = add_start_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_id      = rsp_id_q;
   assign bus.rsp_sum     = rsp_sum_q;
   assign bus.rsp_timeout = rsp_timeout_q;
   assign bus.op_count    = op_count_q;
   assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_bf16_adder_arbiter.sv
// Bench for bf16_adder_arbiter: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a transaction-level
// model of the arbiter's promised behaviour.
module tb_bf16_adder_arbiter;
   localparam int NUM_REQ = 4;
   localparam int TIMEOUT = 8;
   localparam int IDW     = 2;

   // ---------------- clock / reset ----------------
   logic clock   = 1'b0;
   logic n_reset = 1'b0;
   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   bf16_adder_arbiter_if #(.NUM_REQ(NUM_REQ), .IDW(IDW)) bus ();

   bf16_adder_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
      .clock   (clock),
      .n_reset (n_reset),
      .bus     (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- bench adder ----------------
   // Latency and result are functions of the operands unless overridden.
   logic        ovr_en  = 1'b0;
   int          ovr_lat = 0;
   logic [15:0] ovr_sum = 16'h0;
   logic        inject_done = 1'b0;
   int          done_at = -1;
   logic [15:0] done_sum = 16'h0;

   function automatic int eff_lat(input logic [15:0] a, input logic [15:0] b);
      if (ovr_en) return ovr_lat;
      return int'((a ^ b) % 16'd10) + 1;
   endfunction

   function automatic logic [15:0] eff_sum(input logic [15:0] a, input logic [15:0] b);
      if (ovr_en) return ovr_sum;
      return a ^ {b[7:0], b[15:8]};
   endfunction

   always @(negedge clock) begin : adder_accept
      int l;
      if (n_reset && bus.add_start) begin
         l        = eff_lat(bus.add_a, bus.add_b);
         done_at  = (l > 0) ? cyc + l : -1;
         done_sum = eff_sum(bus.add_a, bus.add_b);
      end
   end

   always @(posedge clock) begin : adder_drive
      #1;
      bus.add_done = (cyc == done_at) || inject_done;
      bus.add_sum  = (cyc == done_at) ? done_sum : 16'($urandom);
   end

   // ---------------- scoreboard / model ----------------
   logic [18:0] exp_q[$];   // {id[1:0], timeout, sum[15:0]}
   logic        busy    = 1'b0;
   int          g_cyc   = 0;
   int          rsp_cyc = 0;
   int          ptr_m   = NUM_REQ - 1;
   logic [15:0] count_m = 16'h0;
   logic [15:0] ga_m    = 16'h0;
   logic [15:0] gb_m    = 16'h0;

   function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int p);
      for (int k = 1; k <= NUM_REQ; k++) begin
         int c = (p + k) % NUM_REQ;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   always @(negedge clock) begin : compare
      logic [NUM_REQ-1:0] exp_rr;
      logic               exp_rv;
      logic [18:0]        head;
      int                 pick;
      int                 lat;
      if (!n_reset) begin
         chk("rst_req_ready", bus.req_ready, 0);
         chk("rst_add_start", bus.add_start, 0);
         chk("rst_add_a", bus.add_a, 0);
         chk("rst_add_b", bus.add_b, 0);
         chk("rst_rsp_valid", bus.rsp_valid, 0);
         chk("rst_rsp_id", bus.rsp_id, 0);
         chk("rst_rsp_sum", bus.rsp_sum, 0);
         chk("rst_rsp_timeout", bus.rsp_timeout, 0);
         chk("rst_op_count", bus.op_count, 0);
         busy    = 1'b0;
         ptr_m   = NUM_REQ - 1;
         count_m = 16'h0;
         exp_q.delete();
      end else begin
         pick   = busy ? -1 : rr_pick(bus.req_valid, ptr_m);
         exp_rr = (pick >= 0) ? NUM_REQ'(1 << pick) : '0;
         chk("req_ready", bus.req_ready, exp_rr);
         chk("add_start", bus.add_start, busy && (cyc == g_cyc + 1));
         if (busy && cyc > g_cyc) begin
            chk("add_a", bus.add_a, ga_m);
            chk("add_b", bus.add_b, gb_m);
         end
         exp_rv = busy && (cyc >= rsp_cyc);
         chk("rsp_valid", bus.rsp_valid, exp_rv);
         if (exp_rv && exp_q.size() > 0) begin
            head = exp_q[0];
            chk("rsp_id", bus.rsp_id, head[18:17]);
            chk("rsp_timeout", bus.rsp_timeout, head[16]);
            chk("rsp_sum", bus.rsp_sum, head[15:0]);
         end
         chk("op_count", bus.op_count, count_m);
         if (exp_rv && bus.rsp_ready) begin
            busy    = 1'b0;
            ptr_m   = int'(head[18:17]);
            count_m = count_m + 16'd1;
            void'(exp_q.pop_front());
         end
         if (pick >= 0) begin
            busy  = 1'b1;
            g_cyc = cyc;
            ga_m  = bus.req_a[16*pick +: 16];
            gb_m  = bus.req_b[16*pick +: 16];
            lat   = eff_lat(ga_m, gb_m);
            if (lat >= 1 && lat <= TIMEOUT) begin
               rsp_cyc = cyc + lat + 2;
               exp_q.push_back({2'(pick), 1'b0, eff_sum(ga_m, gb_m)});
            end else begin
               rsp_cyc = cyc + TIMEOUT + 2;
               exp_q.push_back({2'(pick), 1'b1, 16'h7FC1});
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clock);
      #3 n_reset = 1'b0;
      repeat (2) @(negedge clock);
      #1 n_reset = 1'b1;
      step();
   endtask

   // One operation on requester id; hold>0 keeps rsp_ready low that many cycles.
   task automatic directed_op(input int id, input logic [15:0] a, input logic [15:0] b,
                              input int lat, input logic [15:0] sum, input int hold,
                              output int t_gnt, output int t_start, output int t_rsp,
                              output logic [15:0] r_sum, output logic r_to, output int r_id);
      logic [15:0] cnt0;
      t_gnt = -1; t_start = -1; t_rsp = -1; r_sum = 16'h0; r_to = 1'b0; r_id = -1;
      ovr_en = 1'b1; ovr_lat = lat; ovr_sum = sum;
      bus.req_a[16*id +: 16] = a;
      bus.req_b[16*id +: 16] = b;
      bus.req_valid[id]      = 1'b1;
      bus.rsp_ready          = (hold == 0);
      for (int n = 0; n < 20; n++) begin
         @(negedge clock);
         if (bus.req_ready[id]) begin t_gnt = cyc; break; end
      end
      step();
      bus.req_valid[id] = 1'b0;
      if (t_gnt < 0) begin
         chk("grant_seen", 0, 1);
         ovr_en = 1'b0;
         return;
      end
      for (int n = 0; n < 5; n++) begin
         @(negedge clock);
         if (bus.add_start) begin t_start = cyc; break; end
      end
      if (t_start < 0) @(negedge clock);
      for (int n = 0; n < 40; n++) begin
         if (bus.rsp_valid) begin
            t_rsp = cyc; r_sum = bus.rsp_sum; r_to = bus.rsp_timeout; r_id = int'(bus.rsp_id);
            break;
         end
         @(negedge clock);
      end
      if (t_rsp < 0) chk("rsp_seen", 0, 1);
      if (hold > 0 && t_rsp >= 0) begin
         cnt0 = bus.op_count;
         for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_sum", bus.rsp_sum, r_sum);
            chk("bp_id", bus.rsp_id, r_id);
            chk("bp_no_grant", bus.req_ready, 0);
            chk("bp_count", bus.op_count, cnt0);
         end
         @(posedge clock);
         #1 bus.rsp_ready = 1'b1;
         @(negedge clock);
      end
      step();
      ovr_en = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      int tg, ts, tr, rid, idx;
      logic [15:0] rs;
      logic rto;
      int gq[$];
      int rq[$];
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      do_reset();

      // Single request: 1.0 + 1.0, adder answers 5 cycles after start.
      directed_op(0, 16'h3F80, 16'h3F80, 5, 16'h4000, 0, tg, ts, tr, rs, rto, rid);
      chk("single_start_lat", ts - tg, 1);
      chk("single_rsp_lat", tr - tg, 7);
      chk("single_sum", rs, 16'h4000);
      chk("single_id", rid, 0);
      chk("single_timeout", rto, 0);
      @(negedge clock);
      chk("single_op_count", bus.op_count, 1);
      step();

      // Round-robin with all requesters always valid.
      do_reset();
      ovr_en = 1'b1; ovr_lat = 2; ovr_sum = 16'h1234;
      bus.rsp_ready = 1'b1;
      bus.req_valid = '1;
      for (int n = 0; n < 120 && rq.size() < 5; n++) begin
         @(negedge clock);
         for (int i = 0; i < NUM_REQ; i++)
            if (bus.req_ready[i] && gq.size() < 5) gq.push_back(i);
         if (bus.rsp_valid && bus.rsp_ready) rq.push_back(int'(bus.rsp_id));
      end
      step();
      bus.req_valid = '0;
      ovr_en = 1'b0;
      chk("rr_grant_count", gq.size(), 5);
      chk("rr_rsp_count", rq.size(), 5);
      for (int i = 0; i < 5; i++) begin
         chk("rr_grant_order", (i < gq.size()) ? gq[i] : -1, i % NUM_REQ);
         chk("rr_rsp_order", (i < rq.size()) ? rq[i] : -1, i % NUM_REQ);
      end
      repeat (4) step();

      // Backpressure with another requester waiting.
      bus.req_valid[2] = 1'b1;
      bus.req_a[47:32] = 16'h4040;
      bus.req_b[47:32] = 16'h3F80;
      directed_op(1, 16'h4000, 16'h3F80, 3, 16'h4040, 10, tg, ts, tr, rs, rto, rid);
      chk("bp_rsp_sum", rs, 16'h4040);
      chk("bp_rsp_id", rid, 1);
      idx = -1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clock);
         if (bus.req_ready[2]) begin idx = 2; break; end
      end
      chk("bp_next_grant", idx, 2);
      step();
      bus.req_valid = '0;
      repeat (16) step();

      // Timeout: adder never answers.
      directed_op(0, 16'h1111, 16'h2222, 0, 16'h0, 0, tg, ts, tr, rs, rto, rid);
      chk("to_rsp_lat", tr - tg, TIMEOUT + 2);
      chk("to_sum", rs, 16'h7FC1);
      chk("to_flag", rto, 1);
      @(negedge clock);
      inject_done = 1'b1;
      @(negedge clock);
      inject_done = 1'b0;
      repeat (3) step();
      directed_op(3, 16'h3F00, 16'h0000, 4, 16'h3F00, 0, tg, ts, tr, rs, rto, rid);
      chk("after_to_lat", tr - tg, 6);
      chk("after_to_sum", rs, 16'h3F00);
      chk("after_to_flag", rto, 0);
      chk("after_to_id", rid, 3);

      // Done coincides with the last watchdog cycle.
      directed_op(2, 16'hBF80, 16'hBF80, TIMEOUT, 16'hC000, 0, tg, ts, tr, rs, rto, rid);
      chk("coinc_sum", rs, 16'hC000);
      chk("coinc_flag", rto, 0);
      chk("coinc_lat", tr - tg, TIMEOUT + 2);

      // Randomized traffic.
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if ($urandom_range(0, 3) == 0) bus.req_valid[i] = ~bus.req_valid[i];
            bus.req_a[16*i +: 16] = 16'($urandom);
            bus.req_b[16*i +: 16] = 16'($urandom);
         end
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      repeat (20) step();

      // Reset while waiting on the adder.
      ovr_en = 1'b1; ovr_lat = 6; ovr_sum = 16'h1111;
      bus.req_a[31:16] = 16'h3F80;
      bus.req_b[31:16] = 16'h3F80;
      bus.req_valid[1] = 1'b1;
      tg = -1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clock);
         if (bus.req_ready[1]) begin tg = cyc; break; end
      end
      chk("rw_grant", tg >= 0, 1);
      step();
      bus.req_valid = '0;
      @(negedge clock);
      chk("rw_start", bus.add_start, 1);
      @(posedge clock);
      #3 n_reset = 1'b0;
      #1;
      chk("rw_async_rsp_valid", bus.rsp_valid, 0);
      chk("rw_async_add_a", bus.add_a, 0);
      chk("rw_async_add_b", bus.add_b, 0);
      chk("rw_async_op_count", bus.op_count, 0);
      chk("rw_async_rsp_sum", bus.rsp_sum, 0);
      chk("rw_async_rsp_id", bus.rsp_id, 0);
      @(negedge clock);
      @(negedge clock);
      #1 n_reset = 1'b1;
      repeat (7) @(negedge clock);
      step();
      ovr_en = 1'b0;
      bus.req_valid = 4'b0101;
      idx = -1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clock);
         for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) idx = i;
         if (idx >= 0) break;
      end
      chk("rw_first_grant", idx, 0);
      step();
      bus.req_valid[0] = 1'b0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clock);
         if (bus.req_ready[2]) break;
      end
      step();
      bus.req_valid = '0;
      repeat (16) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute guard so the run always ends.
   initial begin : watchdog
      #400000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
